// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter sequencing: one idle cycle, then the zero-fill sweep, then normal service
  typedef enum logic [1:0] {
    START = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2
  } arb_state_e;

  // Which requester owns the memory port in the current cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_D    = 2'd2
  } port_sel_e;

  // Per-port response bookkeeping carried from the grant cycle into the response cycle
  typedef struct packed {
    logic valid;
    logic err;
    logic rd;
  } rsp_flags_t;

  // True when a 32-bit word address falls inside a memory of 2**aw words
  function automatic logic addrInRange(input logic [31:0] addr, input int unsigned aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store unit.
// Data requests win by default; a starvation counter lets fetch through once
// after STARVE_MAX consecutive denials. After each reset the memory is swept
// to zero before any request is served, so the array itself needs no reset.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int AW         = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          init_done
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] FILL_LAST  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_e     state_q, state_d;
  logic [AW-1:0]  fillCnt_q, fillCnt_d;
  logic [SW-1:0]  starveCnt_q, starveCnt_d;
  rsp_flags_t     ifRsp_q, ifRsp_d;
  rsp_flags_t     dRsp_q, dRsp_d;
  port_sel_e      sel;
  logic           ifInRange;
  logic           dInRange;
  logic           fillLast;

  assign ifInRange = addrInRange(if_addr, AW);
  assign dInRange  = addrInRange(d_addr, AW);
  assign fillLast  = (fillCnt_q == FILL_LAST);

  // State register; reset always restarts the fill sequence from START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: START is a single cycle, INIT ends after the last word is cleared
  always_comb begin
    state_d = state_q;
    case (state_q)
      START:   state_d = INIT;
      INIT:    state_d = fillLast ? RUN : INIT;
      RUN:     state_d = RUN;
      default: state_d = START;
    endcase
  end

  // Output logic: fill writes in INIT, winner selection and memory steering in RUN
  always_comb begin
    sel       = SEL_NONE;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      INIT: begin
        mem_we   = 1'b1;
        mem_addr = fillCnt_q;
      end
      RUN: begin
        if (d_req && if_req) begin
          sel = (starveCnt_q == STARVE_TOP) ? SEL_IF : SEL_D;
        end else if (d_req) begin
          sel = SEL_D;
        end else if (if_req) begin
          sel = SEL_IF;
        end
        case (sel)
          SEL_D: begin
            if (dInRange) begin
              mem_addr = d_addr[AW-1:0];
              mem_we   = d_we;
              if (d_we) begin
                mem_wdata = d_wdata;
              end
            end
          end
          SEL_IF: begin
            if (ifInRange) begin
              mem_addr = if_addr[AW-1:0];
            end
          end
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  assign if_gnt    = (sel == SEL_IF);
  assign d_gnt     = (sel == SEL_D);
  assign init_done = (state_q == RUN);

  // Fill counter walks the address space once during INIT
  always_comb begin
    fillCnt_d = fillCnt_q;
    if (state_q == INIT) begin
      fillCnt_d = fillCnt_q + 1'b1;
    end
  end

  // Fill counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fillCnt_q <= '0;
    end else begin
      fillCnt_q <= fillCnt_d;
    end
  end

  // Starvation counter counts consecutive denied fetch cycles and saturates
  always_comb begin
    starveCnt_d = '0;
    if (if_req && !if_gnt) begin
      starveCnt_d = (starveCnt_q == STARVE_TOP) ? STARVE_TOP : starveCnt_q + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

  // Capture what each grant must answer with on the following cycle
  always_comb begin
    ifRsp_d       = '0;
    dRsp_d        = '0;
    ifRsp_d.valid = if_gnt;
    ifRsp_d.err   = if_gnt && !ifInRange;
    ifRsp_d.rd    = 1'b1;
    dRsp_d.valid  = d_gnt;
    dRsp_d.err    = d_gnt && !dInRange;
    dRsp_d.rd     = !d_we;
  end

  // Response flags; reset drops any response still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifRsp_q <= '0;
      dRsp_q  <= '0;
    end else begin
      ifRsp_q <= ifRsp_d;
      dRsp_q  <= dRsp_d;
    end
  end

  assign if_rvalid = ifRsp_q.valid;
  assign if_err    = ifRsp_q.valid && ifRsp_q.err;
  assign if_rdata  = (ifRsp_q.valid && !ifRsp_q.err && ifRsp_q.rd) ? mem_rdata : '0;
  assign d_rvalid  = dRsp_q.valid;
  assign d_err     = dRsp_q.valid && dRsp_q.err;
  assign d_rdata   = (dRsp_q.valid && !dRsp_q.err && dRsp_q.rd) ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared instruction/data word memory between the fetch stage and the load/store unit. Grants at most one access per cycle, with data priority and a bounded-starvation guard for fetch. Returns read data one cycle after grant. After every reset it zero-fills the memory with a sequenced sweep, so the memory array needs no reset logic of its own.

## Interface
- DEPTH, 512: memory depth in 32-bit words; must be a power of two.
- AW, 9: memory address width, equal to log2(DEPTH).
- STARVE_MAX, 4: consecutive denied fetch cycles after which fetch wins once.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch word address (pc >> 2).
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetch data; 0 when if_rvalid=0.
- if_err  out  1  with if_rvalid: address out of range.
- d_req  in  1  data request; held with d_addr/d_we/d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data word address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  data response (read data or write ack).
- d_rdata  out  32  read data; 0 for writes and when d_rvalid=0.
- d_err  out  1  with d_rvalid: address out of range.
- mem_addr  out  AW  memory address (combinational).
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, one cycle after the address is presented.
- init_done  out  1  high once zero-fill completes; stays high until reset.

## Operation
- States: START, INIT, RUN. Reset forces START, zeroes the fill counter, the starve counter, both rvalid flags and init_done.
- START: lasts exactly 1 cycle after rst rises. All outputs are 0.
- INIT: drives mem_we=1, mem_wdata=0, mem_addr=fill_cnt. fill_cnt increments 0..DEPTH-1. Moves to RUN after writing DEPTH-1. No grants are issued in START or INIT.
- RUN: each cycle, selects a winner among the asserted requests.
  - Only one request asserted: that requester wins.
  - Both asserted: d wins, unless starve_cnt == STARVE_MAX, in which case if wins.
- starve_cnt:
  - increments (saturating at STARVE_MAX) when if_req=1 and if_gnt=0;
  - clears when if_gnt=1 or if_req=0.
- Winner with addr < DEPTH: mem_addr = addr[AW-1:0]; mem_we = d_we for d, 0 for if.
- Winner with addr >= DEPTH: no memory access (mem_we=0). The grant is still given; the response carries err=1 and rdata=0.
- The fetch port never writes.
- When no grant is issued, mem_we=0, mem_addr=0 and mem_wdata=0.

## Timing
- Grant at cycle t ⇒ rvalid at t+1 for exactly 1 cycle. rdata = mem_rdata (reads) or 0 (writes/err).
- Back-to-back grants every cycle are allowed; throughput is 1 access per cycle.
- A write granted at t followed by a read of the same address granted at t+1 returns the new data at t+2.
- Reset values: every output is 0, including init_done, gnt, rvalid, err, and the mem_* outputs.
- init_done rises on the first RUN cycle: DEPTH+1 cycles after rst rises.
- Reset asserted mid-access: the pending rvalid is dropped and no response is produced. After release, the full START/INIT sequence runs again.
- Requests arriving during INIT are held by the requester and granted from the first RUN cycle.

## Structure
- Shared package mem_arb_pkg: state enum (START/INIT/RUN) and a port-select typedef (SEL_NONE/SEL_IF/SEL_D).
- Single flat module; no sub-module is warranted. The fill counter, starve counter and two response flags are the only sequential state besides the state register.

## Test plan
- Reset release with DEPTH=512: mem_we=1 for 512 cycles on addresses 0..511 with wdata 0; init_done=1 at cycle 513; no gnt before that.
- Data write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle: d_rvalid ack at t+1; read returns 0xDEADBEEF at t+2.
- Fetch and data both request continuously with STARVE_MAX=4: d granted 4 cycles, then if granted once; the pattern repeats 4:1.
- Fetch from addr 600: if_gnt=1, no mem access, if_rvalid=1 / if_err=1 / if_rdata=0 at t+1.
- Fetch only, addr 0..3 back-to-back: if_gnt every cycle, if_rvalid every cycle from t+1, data in order.
- rst pulled low the cycle after a d read grant: d_rvalid stays 0. After release, the INIT sweep repeats and previously written data reads back as 0.
